// File: rtl/unit_scan_par.sv
// unit_scan_par: multi-lane unit/conflict clause scanner over a snapshotted CNF formula and assignment
module unit_scan_par #(
    parameter int NUM_CLAUSES = 16,
    parameter int MAX_LITS    = 4,
    parameter int NUM_VARS    = 16,
    parameter int LANES       = 2,
    localparam int VAR_W = $clog2(NUM_VARS),
    localparam int LIT_W = VAR_W + 1,
    localparam int LEN_W = $clog2(MAX_LITS + 1),
    localparam int CNT_W = $clog2(NUM_CLAUSES + 1),
    localparam int IDX_W = $clog2(NUM_CLAUSES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 find,
    input  logic                                 conflict_first,
    input  logic [NUM_CLAUSES*MAX_LITS*LIT_W-1:0] clause_lits,
    input  logic [NUM_CLAUSES*LEN_W-1:0]          clause_len,
    input  logic [CNT_W-1:0]                      num_clauses,
    input  logic [NUM_VARS-1:0]                   assigned,
    input  logic [NUM_VARS-1:0]                   value,
    output logic                                 busy,
    output logic                                 ended,
    output logic                                 found,
    output logic                                 conflict,
    output logic [LIT_W-1:0]                      lit_found,
    output logic [IDX_W-1:0]                      clause_idx
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0] state_q, state_d;
    logic [CNT_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d;
    logic pend_q, pend_d, cf_q, cf_d;
    logic [LIT_W-1:0] pend_lit_q, pend_lit_d, lit_found_q, lit_found_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d, clause_idx_q, clause_idx_d;
    logic [NUM_CLAUSES*MAX_LITS*LIT_W-1:0] lits_q, lits_d;
    logic [NUM_CLAUSES*LEN_W-1:0] len_q, len_d;
    logic [NUM_VARS-1:0] assigned_q, assigned_d, value_q, value_d;
    logic busy_q, busy_d, ended_q, ended_d, found_q, found_d, conflict_q, conflict_d;

    logic any_hit, any_unit, any_conf, unit_seen;
    logic [IDX_W-1:0] hit_idx, conf_idx, unit_idx;
    logic [LIT_W-1:0] hit_lit, unit_lit;

    // Lane evaluation: first hit of any kind, first conflict and first unit in this group
    always_comb begin
        logic sat;
        int nun, c;
        logic [LIT_W-1:0] lit, ulit;
        any_hit = 1'b0;
        any_unit = 1'b0;
        any_conf = 1'b0;
        unit_seen = 1'b0;
        hit_idx = '0;
        conf_idx = '0;
        unit_idx = '0;
        hit_lit = '0;
        unit_lit = '0;
        sat = 1'b0;
        nun = 0;
        c = 0;
        lit = '0;
        ulit = '0;
        for (int l = 0; l < LANES; l++) begin
            c = int'(ptr_q) + l;
            sat = 1'b0;
            nun = 0;
            ulit = '0;
            for (int s = 0; s < MAX_LITS; s++) begin
                if (c < int'(cnt_q) && s < int'(len_q[c*LEN_W +: LEN_W])) begin
                    lit = lits_q[(c*MAX_LITS+s)*LIT_W +: LIT_W];
                    if (!assigned_q[lit[LIT_W-1:1]]) begin
                        nun++;
                        ulit = lit;
                    end else if (value_q[lit[LIT_W-1:1]] != lit[0]) sat = 1'b1;
                end
            end
            if (c < int'(cnt_q) && !sat && nun <= 1) begin
                if (!any_hit) begin
                    any_hit = 1'b1;
                    any_unit = (nun == 1);
                    hit_idx = IDX_W'(c);
                    hit_lit = (nun == 1) ? ulit : '0;
                end
                if (nun == 0 && !any_conf) begin
                    any_conf = 1'b1;
                    conf_idx = IDX_W'(c);
                end
                if (nun == 1 && !unit_seen) begin
                    unit_seen = 1'b1;
                    unit_idx = IDX_W'(c);
                    unit_lit = ulit;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        pend_d = pend_q;
        pend_lit_d = pend_lit_q;
        pend_idx_d = pend_idx_q;
        cf_d = cf_q;
        lits_d = lits_q;
        len_d = len_q;
        assigned_d = assigned_q;
        value_d = value_q;
        busy_d = busy_q;
        ended_d = 1'b0;
        found_d = found_q;
        conflict_d = conflict_q;
        lit_found_d = lit_found_q;
        clause_idx_d = clause_idx_q;
        if (state_q == IDLE) begin
            if (find) begin
                state_d = SCAN;
                ptr_d = '0;
                cnt_d = (num_clauses > CNT_W'(NUM_CLAUSES)) ? CNT_W'(NUM_CLAUSES) : num_clauses;
                pend_d = 1'b0;
                cf_d = conflict_first;
                lits_d = clause_lits;
                len_d = clause_len;
                assigned_d = assigned;
                value_d = value;
                busy_d = 1'b1;
                found_d = 1'b0;
                conflict_d = 1'b0;
                lit_found_d = '0;
                clause_idx_d = '0;
            end
        end else if (cf_q ? any_conf : any_hit) begin
            state_d = IDLE;
            busy_d = 1'b0;
            ended_d = 1'b1;
            found_d = !cf_q && any_unit;
            conflict_d = cf_q || !any_unit;
            lit_found_d = cf_q ? '0 : hit_lit;
            clause_idx_d = cf_q ? conf_idx : hit_idx;
        end else if (int'(ptr_q) + LANES >= int'(cnt_q)) begin
            // Only conflict_first scans can reach here with a unit outstanding
            state_d = IDLE;
            busy_d = 1'b0;
            ended_d = 1'b1;
            found_d = pend_q || unit_seen;
            lit_found_d = pend_q ? pend_lit_q : unit_seen ? unit_lit : '0;
            clause_idx_d = pend_q ? pend_idx_q : unit_seen ? unit_idx : clause_idx_q;
        end else begin
            ptr_d = ptr_q + CNT_W'(LANES);
            pend_d = pend_q || unit_seen;
            pend_lit_d = pend_q ? pend_lit_q : unit_lit;
            pend_idx_d = pend_q ? pend_idx_q : unit_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            cnt_q <= '0;
            pend_q <= 1'b0;
            pend_lit_q <= '0;
            pend_idx_q <= '0;
            cf_q <= 1'b0;
            lits_q <= '0;
            len_q <= '0;
            assigned_q <= '0;
            value_q <= '0;
            busy_q <= 1'b0;
            ended_q <= 1'b0;
            found_q <= 1'b0;
            conflict_q <= 1'b0;
            lit_found_q <= '0;
            clause_idx_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            pend_q <= pend_d;
            pend_lit_q <= pend_lit_d;
            pend_idx_q <= pend_idx_d;
            cf_q <= cf_d;
            lits_q <= lits_d;
            len_q <= len_d;
            assigned_q <= assigned_d;
            value_q <= value_d;
            busy_q <= busy_d;
            ended_q <= ended_d;
            found_q <= found_d;
            conflict_q <= conflict_d;
            lit_found_q <= lit_found_d;
            clause_idx_q <= clause_idx_d;
        end
    end

    assign busy = busy_q;
    assign ended = ended_q;
    assign found = found_q;
    assign conflict = conflict_q;
    assign lit_found = lit_found_q;
    assign clause_idx = clause_idx_q;
endmodule

// File: tb/tb_unit_scan_par.sv
// tb_unit_scan_par: directed and randomized checks of unit_scan_par against a clause-by-clause reference model
module tb_unit_scan_par;
    localparam int NC = 16, ML = 4, NV = 16, LANES = 2;
    localparam int LIT_W = 5, LEN_W = 3, CNT_W = 5, IDX_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic find = 1'b0;
    logic conflict_first = 1'b0;
    logic [NC*ML*LIT_W-1:0] clause_lits = '0;
    logic [NC*LEN_W-1:0] clause_len = '0;
    logic [CNT_W-1:0] num_clauses = '0;
    logic [NV-1:0] assigned = '0;
    logic [NV-1:0] value = '0;
    logic busy, ended, found, conflict;
    logic [LIT_W-1:0] lit_found;
    logic [IDX_W-1:0] clause_idx;

    always #5 clk = ~clk;

    unit_scan_par #(.NUM_CLAUSES(NC), .MAX_LITS(ML), .NUM_VARS(NV), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .find(find), .conflict_first(conflict_first),
        .clause_lits(clause_lits), .clause_len(clause_len), .num_clauses(num_clauses),
        .assigned(assigned), .value(value), .busy(busy), .ended(ended), .found(found),
        .conflict(conflict), .lit_found(lit_found), .clause_idx(clause_idx)
    );

    int total = 0, bad = 0;
    int tvar[NC][ML];
    bit tneg[NC][ML];
    int tlen[NC];
    int n_cl;
    bit asg[NV], val[NV];

    // Every clause defaults to (x0) with x0 = 1, i.e. satisfied
    task automatic clear_all();
        for (int c = 0; c < NC; c++) begin
            tlen[c] = 1;
            for (int s = 0; s < ML; s++) begin
                tvar[c][s] = 0;
                tneg[c][s] = 1'b0;
            end
        end
        for (int v = 0; v < NV; v++) begin
            asg[v] = 1'b0;
            val[v] = 1'b0;
        end
        asg[0] = 1'b1;
        val[0] = 1'b1;
        n_cl = 0;
    endtask

    task automatic set_cl(input int c, input int len, input int v0, input bit n0, input int v1, input bit n1);
        tlen[c] = len;
        tvar[c][0] = v0;
        tneg[c][0] = n0;
        tvar[c][1] = v1;
        tneg[c][1] = n1;
    endtask

    task automatic setv(input int v, input bit x);
        asg[v] = 1'b1;
        val[v] = x;
    endtask

    task automatic pack();
        for (int c = 0; c < NC; c++) begin
            clause_len[c*LEN_W +: LEN_W] = LEN_W'(tlen[c]);
            for (int s = 0; s < ML; s++)
                clause_lits[(c*ML+s)*LIT_W +: LIT_W] = {4'(tvar[c][s]), tneg[c][s]};
        end
        num_clauses = CNT_W'(n_cl);
        for (int v = 0; v < NV; v++) begin
            assigned[v] = asg[v];
            value[v] = val[v];
        end
    endtask

    // Sequential reading of the formula: results and end latency from the scanning rules
    function automatic void model(input bit cf, output bit ef, output bit ec, output logic [4:0] el,
                                  output int ei, output int elat);
        int n, len, nu;
        bit sat, pend;
        logic [4:0] ul, pl;
        int pi;
        n = n_cl > NC ? NC : n_cl;
        ef = 0; ec = 0; el = '0; ei = 0; elat = 0;
        pend = 0; pl = '0; pi = 0;
        for (int c = 0; c < n; c++) begin
            len = tlen[c] > ML ? ML : tlen[c];
            sat = 0; nu = 0; ul = '0;
            for (int s = 0; s < len; s++) begin
                if (!asg[tvar[c][s]]) begin
                    nu++;
                    ul = {4'(tvar[c][s]), tneg[c][s]};
                end else if (val[tvar[c][s]] != tneg[c][s]) sat = 1;
            end
            if (sat || nu > 1) continue;
            if (nu == 0 || !cf) begin
                ec = (nu == 0);
                ef = (nu == 1);
                el = ul;
                ei = c;
                elat = c / LANES + 1;
                return;
            end
            if (!pend) begin
                pend = 1;
                pl = ul;
                pi = c;
            end
        end
        ef = pend;
        el = pl;
        ei = pi;
        elat = (n == 0) ? 1 : (n + LANES - 1) / LANES;
    endfunction

    task automatic run_scan(input bit cf, input bit b2b, input bit disturb,
                            output int lat, output bit busy0, output bit clr0);
        pack();
        if (!b2b) @(negedge clk);
        conflict_first = cf;
        find = 1'b1;
        @(posedge clk);
        #1;
        find = 1'b0;
        busy0 = busy;
        clr0 = !(found || conflict || lit_found != 0 || clause_idx != 0);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (ended) break;
            if (disturb) begin
                find = 1'($urandom);
                assigned = NV'($urandom);
                conflict_first = 1'($urandom);
            end
        end
        find = 1'b0;
        if (!ended) lat = -1;
    endtask

    task automatic setup_unit_search();
        clear_all();
        set_cl(0, 2, 1, 0, 2, 0);
        set_cl(1, 2, 3, 0, 4, 1);
        set_cl(2, 1, 7, 0, 0, 0);
        set_cl(3, 2, 5, 0, 6, 1);
        setv(1, 1);
        setv(7, 1);
        setv(5, 0);
        n_cl = 4;
    endtask

    task automatic setup_mode();
        clear_all();
        set_cl(1, 1, 3, 0, 0, 0);
        set_cl(4, 1, 8, 0, 0, 0);
        setv(8, 0);
        n_cl = 6;
    endtask

    task automatic test_reset_state();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, ended, found, conflict, lit_found, clause_idx} !== 13'd0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0", {busy, ended, found, conflict, lit_found, clause_idx});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unit_search();
        int lat;
        bit b0, c0;
        setup_unit_search();
        run_scan(0, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx} !== {1'b1, 1'b0, 5'd13, 4'd3}) begin
            bad++;
            $display("FAIL unit_search got=%h exp=%h", {found, conflict, lit_found, clause_idx}, {1'b1, 1'b0, 5'd13, 4'd3});
        end
        total++;
        if (lat !== 2 || b0 !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL unit_search_timing lat=%0d busy0=%0b busy_end=%0b exp lat=2 busy0=1 busy_end=0", lat, b0, busy);
        end
    endtask

    task automatic test_mode();
        int lat;
        bit b0, c0;
        setup_mode();
        run_scan(0, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b1, 1'b0, 5'd6, 4'd1, 8'd1}) begin
            bad++;
            $display("FAIL mode_cf0 got=%h lat=%0d exp=found idx1 lit6 lat1", {found, conflict, lit_found, clause_idx}, lat);
        end
        run_scan(1, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b0, 1'b1, 5'd0, 4'd4, 8'd3}) begin
            bad++;
            $display("FAIL mode_cf1_conflict got=%h lat=%0d exp=conflict idx4 lat3", {found, conflict, lit_found, clause_idx}, lat);
        end
        setv(8, 1);
        run_scan(1, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b1, 1'b0, 5'd6, 4'd1, 8'd3}) begin
            bad++;
            $display("FAIL mode_cf1_pending got=%h lat=%0d exp=found idx1 lit6 lat3", {found, conflict, lit_found, clause_idx}, lat);
        end
    endtask

    task automatic test_lane_tie();
        int lat;
        bit b0, c0;
        clear_all();
        set_cl(0, 1, 2, 0, 0, 0);
        set_cl(1, 1, 3, 0, 0, 0);
        n_cl = 2;
        run_scan(0, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b1, 1'b0, 5'd4, 4'd0, 8'd1}) begin
            bad++;
            $display("FAIL lane_tie got=%h lat=%0d exp=found idx0 lit4 lat1", {found, conflict, lit_found, clause_idx}, lat);
        end
        @(posedge clk);
        #1;
        total++;
        if (ended !== 1'b0 || found !== 1'b1) begin
            bad++;
            $display("FAIL ended_pulse ended=%0b found=%0b exp ended=0 found=1", ended, found);
        end
        clear_all();
        set_cl(0, 2, 9, 0, 9, 0);
        n_cl = 2;
        run_scan(0, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b0, 1'b0, 5'd0, 4'd0, 8'd1}) begin
            bad++;
            $display("FAIL duplicate_lit got=%h lat=%0d exp=none lat1", {found, conflict, lit_found, clause_idx}, lat);
        end
    endtask

    task automatic test_bounds();
        int lat;
        bit b0, c0;
        clear_all();
        run_scan(0, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b0, 1'b0, 5'd0, 4'd0, 8'd1}) begin
            bad++;
            $display("FAIL empty_formula got=%h lat=%0d exp=none lat1", {found, conflict, lit_found, clause_idx}, lat);
        end
        n_cl = 20;
        run_scan(1, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b0, 1'b0, 5'd0, 4'd0, 8'd8}) begin
            bad++;
            $display("FAIL count_clamp got=%h lat=%0d exp=none lat8", {found, conflict, lit_found, clause_idx}, lat);
        end
        clear_all();
        set_cl(0, 7, 1, 0, 1, 0);
        tvar[0][2] = 1;
        tvar[0][3] = 4;
        setv(1, 0);
        n_cl = 1;
        run_scan(0, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b1, 1'b0, 5'd8, 4'd0, 8'd1}) begin
            bad++;
            $display("FAIL len_clamp got=%h lat=%0d exp=found idx0 lit8 lat1", {found, conflict, lit_found, clause_idx}, lat);
        end
        clear_all();
        tlen[2] = 0;
        n_cl = 3;
        run_scan(0, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b0, 1'b1, 5'd0, 4'd2, 8'd2}) begin
            bad++;
            $display("FAIL len_zero got=%h lat=%0d exp=conflict idx2 lat2", {found, conflict, lit_found, clause_idx}, lat);
        end
    endtask

    task automatic test_busy();
        int lat;
        bit b0, c0;
        setup_unit_search();
        run_scan(0, 0, 1, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b1, 1'b0, 5'd13, 4'd3, 8'd2}) begin
            bad++;
            $display("FAIL busy_ignore got=%h lat=%0d exp=found idx3 lit13 lat2", {found, conflict, lit_found, clause_idx}, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit b0, c0;
        setup_mode();
        run_scan(0, 0, 0, lat, b0, c0);
        clear_all();
        n_cl = 4;
        run_scan(0, 1, 0, lat, b0, c0);
        total++;
        if (b0 !== 1'b1 || c0 !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back_accept busy=%0b cleared=%0b exp busy=1 cleared=1", b0, c0);
        end
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b0, 1'b0, 5'd0, 4'd0, 8'd2}) begin
            bad++;
            $display("FAIL back_to_back_result got=%h lat=%0d exp=none lat2", {found, conflict, lit_found, clause_idx}, lat);
        end
    endtask

    task automatic test_reset();
        int lat;
        bit b0, c0, seen;
        setup_unit_search();
        run_scan(0, 0, 0, lat, b0, c0);
        clear_all();
        n_cl = 16;
        pack();
        @(negedge clk);
        find = 1'b1;
        @(posedge clk);
        #1;
        find = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen |= ended;
        end
        total++;
        if ({busy, ended, found, conflict, lit_found, clause_idx} !== 13'd0) begin
            bad++;
            $display("FAIL reset_mid_scan got=%h exp=0", {busy, ended, found, conflict, lit_found, clause_idx});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen |= ended | busy;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_ended got=%0b exp=0", seen);
        end
        setup_unit_search();
        run_scan(0, 0, 0, lat, b0, c0);
        total++;
        if ({found, conflict, lit_found, clause_idx, 8'(lat)} !== {1'b1, 1'b0, 5'd13, 4'd3, 8'd2}) begin
            bad++;
            $display("FAIL reset_resume got=%h lat=%0d exp=found idx3 lit13 lat2", {found, conflict, lit_found, clause_idx}, lat);
        end
    endtask

    task automatic test_random();
        int lat, ei, elat, r;
        bit b0, c0, ef, ec, cf;
        logic [4:0] el;
        for (int it = 0; it < 60; it++) begin
            n_cl = $urandom_range(0, 20);
            for (int c = 0; c < NC; c++) begin
                r = $urandom_range(0, 15);
                tlen[c] = (r == 0) ? 0 : (r > 12) ? $urandom_range(5, 7) : $urandom_range(1, 4);
                for (int s = 0; s < ML; s++) begin
                    tvar[c][s] = $urandom_range(0, NV - 1);
                    tneg[c][s] = 1'($urandom);
                end
            end
            for (int v = 0; v < NV; v++) begin
                asg[v] = ($urandom_range(0, 3) != 0);
                val[v] = 1'($urandom);
            end
            cf = 1'($urandom);
            model(cf, ef, ec, el, ei, elat);
            run_scan(cf, 0, it[0], lat, b0, c0);
            total++;
            if ({found, conflict, lit_found, clause_idx} !== {ef, ec, el, 4'(ei)} || lat !== elat) begin
                bad++;
                $display("FAIL random it=%0d got=%h lat=%0d exp=%h lat=%0d", it, {found, conflict, lit_found, clause_idx}, lat, {ef, ec, el, 4'(ei)}, elat);
            end
        end
    endtask

    initial begin
        test_reset_state();
        test_unit_search();
        test_mode();
        test_lane_tie();
        test_bounds();
        test_busy();
        test_back_to_back();
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
